// File: rtl/dpmem_sched.sv
// dpmem_sched: shares one dual-port memory (1R/1W) between two requesters.
// The read and write ports each have their own round-robin arbiter.
// Read responses appear one cycle after the grant. A same-cycle write to the
// read address is forwarded through a bypass register, so reads see the new data.
module dpmem_sched #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_ra,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [DATA_W-1:0] mem_wd,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // Two-way round-robin pick. Bit 0 is the grant for requester 0 and bit 1 is the grant for requester 1.
    // When both requesters compete, the one that did not win last time gets the grant.
    function automatic logic [1:0] rr_pick(input logic c0, input logic c1, input logic last);
        logic [1:0] g;
        g[0] = c0 && (!c1 || last);
        g[1] = c1 && (!c0 || !last);
        return g;
    endfunction

    logic              rd_cand0_s, rd_cand1_s, wr_cand0_s, wr_cand1_s;
    logic [1:0]        rd_gnt_s, wr_gnt_s;
    logic              rd_any_s, wr_any_s;
    logic              contention_s;
    logic [ADDR_W-1:0] rd_addr_s, wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    logic              rd_last_r, wr_last_r;
    logic              rsp0_valid_r, rsp1_valid_r;
    logic              byp_r;
    logic [DATA_W-1:0] byp_data_r;
    logic [CNT_W-1:0]  conflict_cnt_r;

    // Find the candidates for each port. Reset masks them, so no grant is issued while rst is high.
    always_comb begin
        rd_cand0_s   = req0_valid && !req0_write && !rst;
        rd_cand1_s   = req1_valid && !req1_write && !rst;
        wr_cand0_s   = req0_valid &&  req0_write && !rst;
        wr_cand1_s   = req1_valid &&  req1_write && !rst;
        contention_s = (req0_valid && req1_valid && (req0_write == req1_write));
        rd_gnt_s     = rr_pick(rd_cand0_s, rd_cand1_s, rd_last_r);
        wr_gnt_s     = rr_pick(wr_cand0_s, wr_cand1_s, wr_last_r);
        rd_any_s     = |rd_gnt_s;
        wr_any_s     = |wr_gnt_s;
    end

    // Select the granted command fields. A port with no grant drives zeros.
    always_comb begin
        rd_addr_s = '0;
        wr_addr_s = '0;
        wr_data_s = '0;
        if (rd_gnt_s[0]) begin
            rd_addr_s = req0_addr;
        end else if (rd_gnt_s[1]) begin
            rd_addr_s = req1_addr;
        end else begin
            rd_addr_s = '0;
        end
        if (wr_gnt_s[0]) begin
            wr_addr_s = req0_addr;
            wr_data_s = req0_wdata;
        end else if (wr_gnt_s[1]) begin
            wr_addr_s = req1_addr;
            wr_data_s = req1_wdata;
        end else begin
            wr_addr_s = '0;
            wr_data_s = '0;
        end
    end

    // Update the arbitration pointers, the response tags, the bypass capture and the saturating contention counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_last_r      <= 1'b1;
            wr_last_r      <= 1'b1;
            rsp0_valid_r   <= 1'b0;
            rsp1_valid_r   <= 1'b0;
            byp_r          <= 1'b0;
            byp_data_r     <= '0;
            conflict_cnt_r <= '0;
        end else begin
            if (rd_any_s) begin
                rd_last_r <= rd_gnt_s[1];
            end else begin
                rd_last_r <= rd_last_r;
            end
            if (wr_any_s) begin
                wr_last_r <= wr_gnt_s[1];
            end else begin
                wr_last_r <= wr_last_r;
            end
            rsp0_valid_r <= rd_gnt_s[0];
            rsp1_valid_r <= rd_gnt_s[1];
            byp_r        <= rd_any_s && wr_any_s && (rd_addr_s == wr_addr_s);
            byp_data_r   <= wr_data_s;
            if (contention_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
                conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    // Drive the outputs. Read data comes from the memory or from the bypass register, and is zero when no response is valid.
    always_comb begin
        req0_ready   = rd_gnt_s[0] || wr_gnt_s[0];
        req1_ready   = rd_gnt_s[1] || wr_gnt_s[1];
        mem_ra       = rd_addr_s;
        mem_we       = wr_any_s;
        mem_wa       = wr_addr_s;
        mem_wd       = wr_data_s;
        rsp0_valid   = rsp0_valid_r;
        rsp1_valid   = rsp1_valid_r;
        conflict_cnt = conflict_cnt_r;
        if (rsp0_valid_r) begin
            rsp0_rdata = byp_r ? byp_data_r : mem_rd;
        end else begin
            rsp0_rdata = '0;
        end
        if (rsp1_valid_r) begin
            rsp1_rdata = byp_r ? byp_data_r : mem_rd;
        end else begin
            rsp1_rdata = '0;
        end
    end

endmodule

// File: tb/tb_dpmem_sched.sv
// Directed testbench for dpmem_sched. It includes a read-first 16x4 memory model that is re-initialised on reset.
module tb_dpmem_sched;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_write, req0_ready, rsp0_valid;
    logic [3:0] req0_addr, req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_write, req1_ready, rsp1_valid;
    logic [3:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [3:0] mem_ra, mem_rd, mem_wa, mem_wd;
    logic       mem_we;
    logic [7:0] conflict_cnt;
    logic [3:0] tb_mem [16];

    int n_chk;
    int n_pass;

    dpmem_sched #(.ADDR_W(4), .DATA_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_wa(mem_wa), .mem_wd(mem_wd), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first memory model. On reset, location i is set to 15-i.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 4'(15 - i);
        end else if (mem_we) begin
            tb_mem[mem_wa] <= mem_wd;
        end
        mem_rd <= tb_mem[mem_ra];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [3:0] a0, input logic [3:0] d0,
                         input logic v1, input logic w1, input logic [3:0] a1, input logic [3:0] d1);
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        tick();
        // A read is pending while reset is asserted. It must not be granted.
        drive(1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("rst_ready0", 32'(req0_ready), 32'd0);
        check_val("rst_mem_ra", 32'(mem_ra), 32'd0);
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("post_rst_rsp0", 32'(rsp0_valid), 32'd0);
        check_val("post_rst_cnt", 32'(conflict_cnt), 32'd0);

        // Test 1: write 3 <- A, then read 3.
        drive(1'b1, 1'b1, 4'h3, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("t1_wr_ready", 32'(req0_ready), 32'd1);
        check_val("t1_mem_we", 32'(mem_we), 32'd1);
        check_val("t1_mem_wa", 32'(mem_wa), 32'd3);
        check_val("t1_mem_wd", 32'(mem_wd), 32'hA);
        tick();
        drive(1'b1, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("t1_rd_ready", 32'(req0_ready), 32'd1);
        check_val("t1_mem_ra", 32'(mem_ra), 32'd3);
        check_val("t1_rsp0_early", 32'(rsp0_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check_val("t1_rsp0_rdata", 32'(rsp0_rdata), 32'hA);
        check_val("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);

        // Test 2: both requesters read (addr 1 and addr 2) on 4 consecutive cycles after a reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 4'h2, 4'h0);
            #1;
            check_val("t2_ready0", 32'(req0_ready), 32'((k % 2) == 0));
            check_val("t2_ready1", 32'(req1_ready), 32'((k % 2) == 1));
            check_val("t2_cnt", 32'(conflict_cnt), 32'(k));
            if (k > 0) begin
                check_val("t2_rsp0_valid", 32'(rsp0_valid), 32'(((k - 1) % 2) == 0));
                check_val("t2_rsp1_valid", 32'(rsp1_valid), 32'(((k - 1) % 2) == 1));
                if ((k - 1) % 2 == 0) check_val("t2_rsp0_rdata", 32'(rsp0_rdata), 32'd14);
                else check_val("t2_rsp1_rdata", 32'(rsp1_rdata), 32'd13);
            end
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("t2_last_rsp1", 32'(rsp1_valid), 32'd1);
        check_val("t2_last_rdata", 32'(rsp1_rdata), 32'd13);
        check_val("t2_cnt_final", 32'(conflict_cnt), 32'd4);

        // Test 3: set mem[5] = 2. Then write 5 <- 7 in the same cycle as a read of 5. The read must see 7 via the bypass.
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h5, 4'h2);
        #1;
        check_val("t3_pre_ready1", 32'(req1_ready), 32'd1);
        tick();
        drive(1'b1, 1'b1, 4'h5, 4'h7, 1'b1, 1'b0, 4'h5, 4'h0);
        #1;
        check_val("t3_ready0", 32'(req0_ready), 32'd1);
        check_val("t3_ready1", 32'(req1_ready), 32'd1);
        tick();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h5, 4'h0);
        #1;
        check_val("t3_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check_val("t3_bypass_rdata", 32'(rsp1_rdata), 32'h7);
        check_val("t3_rsp0_valid", 32'(rsp0_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("t3_mem_rdata", 32'(rsp1_rdata), 32'h7);
        check_val("t3_cnt", 32'(conflict_cnt), 32'd4);

        // Test 4: a read of 9 and a write to 4 in the same cycle. Both are granted and there is no contention.
        drive(1'b1, 1'b0, 4'h9, 4'h0, 1'b1, 1'b1, 4'h4, 4'h3);
        #1;
        check_val("t4_ready0", 32'(req0_ready), 32'd1);
        check_val("t4_ready1", 32'(req1_ready), 32'd1);
        check_val("t4_mem_ra", 32'(mem_ra), 32'd9);
        check_val("t4_mem_we", 32'(mem_we), 32'd1);
        check_val("t4_mem_wa", 32'(mem_wa), 32'd4);
        tick();
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("t4_cnt", 32'(conflict_cnt), 32'd4);
        check_val("t4_rsp0_rdata", 32'(rsp0_rdata), 32'd6);

        // Test 5: rd_last is 0 at this point. A read in a reset cycle is squashed, and the next read tie goes to requester 0.
        drive(1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 4'h2, 4'h0);
        #1;
        check_val("t5_rsp0_squash", 32'(rsp0_valid), 32'd0);
        check_val("t5_rsp1_squash", 32'(rsp1_valid), 32'd0);
        check_val("t5_tie_ready0", 32'(req0_ready), 32'd1);
        check_val("t5_tie_ready1", 32'(req1_ready), 32'd0);
        check_val("t5_cnt", 32'(conflict_cnt), 32'd0);
        tick();

        // Test 6: 300 cycles of write contention. conflict_cnt starts at 1 and saturates at 255.
        drive(1'b1, 1'b1, 4'h6, 4'h1, 1'b1, 1'b1, 4'h7, 4'h2);
        for (int i = 0; i < 300; i++) begin
            #1;
            if (i == 0) begin
                check_val("t6_wr_ready0", 32'(req0_ready), 32'd1);
                check_val("t6_wr_ready1", 32'(req1_ready), 32'd0);
            end
            if (i == 1) begin
                check_val("t6_wr_ready0_b", 32'(req0_ready), 32'd0);
                check_val("t6_wr_ready1_b", 32'(req1_ready), 32'd1);
            end
            if (i == 253) check_val("t6_cnt_254", 32'(conflict_cnt), 32'd254);
            if (i == 254) check_val("t6_cnt_255", 32'(conflict_cnt), 32'd255);
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        check_val("t6_cnt_sat", 32'(conflict_cnt), 32'd255);
        check_val("idle_mem_we", 32'(mem_we), 32'd0);
        check_val("idle_mem_ra", 32'(mem_ra), 32'd0);
        check_val("idle_ready0", 32'(req0_ready), 32'd0);
        check_val("idle_rsp0", 32'(rsp0_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
